// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stage-sequencing controller for a 5-stage pipeline. Drives
//               PC / latch write-enables and flushes. Resolves load-use,
//               taken-branch redirect and multi-cycle mult/div occupancy of
//               execute. Keeps saturating stall/flush counters for debug.
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
   parameter int MD_MAX_CYCLES = 40,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          fd_ir,
   input  logic [31:0]          de_ir,
   input  logic                 branch_taken,
   input  logic                 multdiv_ready,
   output logic                 pc_wren,
   output logic                 fd_wren,
   output logic                 fd_flush,
   output logic                 de_wren,
   output logic                 de_flush,
   output logic                 em_bubble,
   output logic                 pc_sel_branch,
   output logic                 multdiv_start,
   output logic                 md_busy,
   output logic                 md_timeout,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events
);

   // Wait counter only has to reach MD_MAX_CYCLES-1
   localparam int WAIT_W = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MD_MAX_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

   localparam logic [4:0] c_op_r    = 5'b00000;
   localparam logic [4:0] c_op_j    = 5'b00001;
   localparam logic [4:0] c_op_bne  = 5'b00010;
   localparam logic [4:0] c_op_jal  = 5'b00011;
   localparam logic [4:0] c_op_jr   = 5'b00100;
   localparam logic [4:0] c_op_addi = 5'b00101;
   localparam logic [4:0] c_op_blt  = 5'b00110;
   localparam logic [4:0] c_op_sw   = 5'b00111;
   localparam logic [4:0] c_op_lw   = 5'b01000;
   localparam logic [4:0] c_alu_mul = 5'b00110;
   localparam logic [4:0] c_alu_div = 5'b00111;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MD_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   logic [WAIT_W-1:0]     r_wait_cnt;
   logic                  r_timeout;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;
   logic [CNT_WIDTH-1:0]  r_flush_cnt;

   // Instruction field extraction
   logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
   logic [4:0] w_de_op, w_de_rd, w_de_alu;
   assign w_fd_op  = fd_ir[31:27];
   assign w_fd_rd  = fd_ir[26:22];
   assign w_fd_rs  = fd_ir[21:17];
   assign w_fd_rt  = fd_ir[16:12];
   assign w_de_op  = de_ir[31:27];
   assign w_de_rd  = de_ir[26:22];
   assign w_de_alu = de_ir[6:2];

   // Fields not involved in hazard detection
   logic w_unused_bits;
   assign w_unused_bits = &{1'b0, fd_ir[11:0], de_ir[21:7], de_ir[1:0]};

   // Which source-register fields the F/D instruction actually reads
   logic w_use_rs, w_use_rt, w_use_rd;
   assign w_use_rs = (w_fd_op == c_op_r)   || (w_fd_op == c_op_addi) ||
                     (w_fd_op == c_op_lw)  || (w_fd_op == c_op_sw)   ||
                     (w_fd_op == c_op_bne) || (w_fd_op == c_op_blt);
   assign w_use_rt = (w_fd_op == c_op_r);
   assign w_use_rd = (w_fd_op == c_op_sw)  || (w_fd_op == c_op_bne)  ||
                     (w_fd_op == c_op_blt) || (w_fd_op == c_op_jr);

   // j/jal read no registers; named here so the opcode map stays complete
   logic w_fd_is_jump;
   assign w_fd_is_jump = (w_fd_op == c_op_j) || (w_fd_op == c_op_jal);

   // Load-use: lw result in D/X needed by F/D; r0 is hard-wired and never hazards
   logic w_lu;
   assign w_lu = (w_de_op == c_op_lw) && (w_de_rd != 5'd0) && !w_fd_is_jump &&
                 ((w_use_rs && (w_fd_rs == w_de_rd)) ||
                  (w_use_rt && (w_fd_rt == w_de_rd)) ||
                  (w_use_rd && (w_fd_rd == w_de_rd)));

   logic w_de_md, w_md_start, w_md_exit;
   assign w_de_md    = (w_de_op == c_op_r) &&
                       ((w_de_alu == c_alu_mul) || (w_de_alu == c_alu_div));
   assign w_md_start = (r_state == ST_RUN) && w_de_md && !branch_taken;
   assign w_md_exit  = (r_state == ST_MD_WAIT) &&
                       (multdiv_ready || (r_wait_cnt == c_wait_last));

   // Prioritised combinational stage control
   always_comb begin
      pc_wren       = 1'b1;
      fd_wren       = 1'b1;
      de_wren       = 1'b1;
      fd_flush      = 1'b0;
      de_flush      = 1'b0;
      em_bubble     = 1'b0;
      pc_sel_branch = 1'b0;
      multdiv_start = 1'b0;
      md_busy       = (r_state == ST_MD_WAIT);
      md_timeout    = r_timeout;
      stall_cycles  = r_stall_cnt;
      flush_events  = r_flush_cnt;
      if (reset) begin
         fd_flush     = 1'b1;
         de_flush     = 1'b1;
         em_bubble    = 1'b1;
         md_busy      = 1'b0;
         md_timeout   = 1'b0;
         stall_cycles = '0;
         flush_events = '0;
      end else if (w_md_start || ((r_state == ST_MD_WAIT) && !w_md_exit)) begin
         pc_wren       = 1'b0;
         fd_wren       = 1'b0;
         de_wren       = 1'b0;
         em_bubble     = 1'b1;
         multdiv_start = w_md_start;
      end else if (w_md_exit) begin
         // mul/div result advances to X/M with all stages free to move
      end else if (branch_taken) begin
         // Wrong-path instructions are squashed, so any load-use is moot
         pc_sel_branch = 1'b1;
         fd_flush      = 1'b1;
         de_flush      = 1'b1;
      end else if (w_lu) begin
         pc_wren  = 1'b0;
         fd_wren  = 1'b0;
         de_flush = 1'b1;
      end
   end

   // Mult/div occupancy FSM with watchdog
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_md_start) begin
                  r_state    <= ST_MD_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            ST_MD_WAIT: begin
               if (w_md_exit) begin
                  r_state <= ST_RUN;
                  if (!multdiv_ready) begin
                     r_timeout <= 1'b1;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Saturating debug counters
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_wren && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
         if (pc_sel_branch && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench for pipeline_hazard_controller
//               with a behavioural reference model and expectation queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_controller;

   localparam int MAXC = 8;
   localparam int CW   = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   fd_ir, de_ir;
   logic          branch_taken, multdiv_ready;
   logic          pc_wren, fd_wren, fd_flush, de_wren, de_flush, em_bubble;
   logic          pc_sel_branch, multdiv_start, md_busy, md_timeout;
   logic [CW-1:0] stall_cycles, flush_events;

   pipeline_hazard_controller #(.MD_MAX_CYCLES(MAXC), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .fd_ir(fd_ir), .de_ir(de_ir),
      .branch_taken(branch_taken), .multdiv_ready(multdiv_ready),
      .pc_wren(pc_wren), .fd_wren(fd_wren), .fd_flush(fd_flush),
      .de_wren(de_wren), .de_flush(de_flush), .em_bubble(em_bubble),
      .pc_sel_branch(pc_sel_branch), .multdiv_start(multdiv_start),
      .md_busy(md_busy), .md_timeout(md_timeout),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clock = ~clock;

   // {pc_wren, fd_wren, fd_flush, de_wren, de_flush, em_bubble,
   //  pc_sel_branch, multdiv_start, md_busy, md_timeout}
   typedef struct packed {
      logic [9:0]    ctl;
      logic [CW-1:0] st;
      logic [CW-1:0] fl;
   } exp_t;

   exp_t q[$];
   int   n_err = 0;
   int   n_chk = 0;

   // Reference model state
   bit m_wait = 0;
   int m_waited = 0;   // MD_WAIT cycles including the current one
   bit m_to = 0;
   int m_stall = 0;
   int m_flush = 0;

   function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                      input int rt, input int alu);
      logic [31:0] v;
      v = '0;
      v[31:27] = op[4:0];
      v[26:22] = rd[4:0];
      v[21:17] = rs[4:0];
      v[16:12] = rt[4:0];
      v[6:2]   = alu[4:0];
      return v;
   endfunction

   // Does instruction i read register r as a source?
   function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
      logic [4:0] op;
      op = i[31:27];
      if (r == 5'd0) return 0;
      case (op)
         5'd0:       return (i[21:17] == r) || (i[16:12] == r);
         5'd5, 5'd8: return (i[21:17] == r);
         5'd7, 5'd2,
         5'd6:       return (i[21:17] == r) || (i[26:22] == r);
         5'd4:       return (i[26:22] == r);
         default:    return 0;
      endcase
   endfunction

   function automatic bit is_md(input logic [31:0] i);
      return (i[31:27] == 5'd0) && ((i[6:2] == 5'd6) || (i[6:2] == 5'd7));
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic [31:0] f,
                      input logic [31:0] d, input logic b, input logic y);
      exp_t e, o;
      bit   start, ext;
      reset = r; fd_ir = f; de_ir = d; branch_taken = b; multdiv_ready = y;
      start = 0;
      ext   = 0;
      if (r) begin
         e.ctl = 10'b11_1111_0000;
         e.st  = '0;
         e.fl  = '0;
      end else begin
         e.st = CW'(m_stall);
         e.fl = CW'(m_flush);
         if (!m_wait && is_md(d) && !b) begin
            start = 1;
            e.ctl = {6'b00_0001, 1'b0, 1'b1, 1'b0, m_to};
         end else if (m_wait) begin
            ext = y || (m_waited == MAXC);
            e.ctl = ext ? {6'b11_0100, 1'b0, 1'b0, 1'b1, m_to}
                        : {6'b00_0001, 1'b0, 1'b0, 1'b1, m_to};
         end else if (b) begin
            e.ctl = {6'b11_1110, 1'b1, 1'b0, 1'b0, m_to};
         end else if ((d[31:27] == 5'd8) && reads(f, d[26:22])) begin
            e.ctl = {6'b00_0110, 1'b0, 1'b0, 1'b0, m_to};
         end else begin
            e.ctl = {6'b11_0100, 1'b0, 1'b0, 1'b0, m_to};
         end
      end
      q.push_back(e);

      @(negedge clock);
      o = q.pop_front();
      chk({tag, ".ctl"}, 16'({pc_wren, fd_wren, fd_flush, de_wren, de_flush, em_bubble,
                              pc_sel_branch, multdiv_start, md_busy, md_timeout}),
          16'(o.ctl));
      chk({tag, ".stall"}, 16'(stall_cycles), 16'(o.st));
      chk({tag, ".flush"}, 16'(flush_events), 16'(o.fl));

      @(posedge clock);
      if (r) begin
         m_wait = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!o.ctl[9] && m_stall < (1 << CW) - 1) m_stall++;
         if (o.ctl[3] && m_flush < (1 << CW) - 1) m_flush++;
         if (start) begin
            m_wait = 1; m_waited = 1;
         end else if (m_wait) begin
            if (ext) begin
               m_wait = 0;
               if (!y) m_to = 1;
            end else begin
               m_waited++;
            end
         end
      end
      #1;
   endtask

   // Directed stimulus sequence
   initial begin
      logic [31:0] nop, add1, add2, lw3, add_rs3, add_rt3, sw3, jr3, addi_rt3;
      logic [31:0] j3, lw0, add_r0, bne3, mul, div;
      nop      = '0;
      add1     = mk(0, 1, 2, 3, 0);
      add2     = mk(0, 4, 5, 6, 0);
      lw3      = mk(8, 3, 4, 0, 0);
      add_rs3  = mk(0, 5, 3, 6, 0);
      add_rt3  = mk(0, 5, 6, 3, 0);
      sw3      = mk(7, 3, 7, 0, 0);
      jr3      = mk(4, 3, 0, 0, 0);
      addi_rt3 = mk(5, 5, 6, 3, 0);
      j3       = mk(1, 3, 3, 3, 0);
      lw0      = mk(8, 0, 4, 0, 0);
      add_r0   = mk(0, 1, 0, 0, 0);
      bne3     = mk(2, 9, 3, 0, 0);
      mul      = mk(0, 8, 1, 2, 6);
      div      = mk(0, 8, 1, 2, 7);

      reset = 1; fd_ir = '0; de_ir = '0; branch_taken = 0; multdiv_ready = 0;
      @(posedge clock); #1;

      cyc("reset0", 1, nop, nop, 0, 0);
      cyc("reset1", 1, add1, mul, 1, 1);
      cyc("plain", 0, add1, add2, 0, 0);

      // Load-use detection over each source field
      cyc("lu_rs", 0, add_rs3, lw3, 0, 0);
      cyc("lu_bubble", 0, add_rs3, nop, 0, 0);
      cyc("lu_rt", 0, add_rt3, lw3, 0, 0);
      cyc("lu_sw", 0, sw3, lw3, 0, 0);
      cyc("lu_jr", 0, jr3, lw3, 0, 0);
      cyc("lu_bne", 0, bne3, lw3, 0, 0);
      cyc("no_lu_addi_rt", 0, addi_rt3, lw3, 0, 0);
      cyc("no_lu_j", 0, j3, lw3, 0, 0);
      cyc("no_lu_r0", 0, add_r0, lw0, 0, 0);

      // Branch overrides load-use
      cyc("br_over_lu", 0, add_rs3, lw3, 1, 0);
      cyc("br_plain", 0, add1, add2, 1, 0);
      cyc("br_kills_md", 0, add1, mul, 1, 0);

      // mul with result five cycles after start; branch in MD_WAIT ignored
      cyc("md_start", 0, add1, mul, 0, 0);
      cyc("md_wait1", 0, add1, mul, 0, 0);
      cyc("md_wait2", 0, add1, mul, 1, 0);
      cyc("md_wait3", 0, add1, mul, 0, 0);
      cyc("md_wait4", 0, add1, mul, 0, 0);
      cyc("md_exit", 0, add1, mul, 0, 1);
      cyc("md_after", 0, add1, nop, 0, 0);

      // div with no result: watchdog releases after MAXC wait cycles
      cyc("wd_start", 0, add1, div, 0, 0);
      for (int i = 0; i < MAXC; i++) cyc("wd_wait", 0, add1, div, 0, 0);
      cyc("wd_after", 0, add1, nop, 0, 0);
      cyc("wd_sticky_br", 0, add1, add2, 1, 0);
      cyc("wd_sticky_lu", 0, add_rs3, lw3, 0, 0);

      // Counter saturation
      for (int i = 0; i < 18; i++) cyc("sat_stall", 0, add_rs3, lw3, 0, 0);
      for (int i = 0; i < 17; i++) cyc("sat_flush", 0, add1, add2, 1, 0);

      // Reset during the third MD_WAIT cycle
      cyc("rw_start", 0, add1, mul, 0, 0);
      cyc("rw_wait1", 0, add1, mul, 0, 0);
      cyc("rw_wait2", 0, add1, mul, 0, 0);
      cyc("rw_reset", 1, add1, mul, 0, 0);
      cyc("rw_post", 0, add1, nop, 0, 0);
      cyc("rw_restart", 0, add1, mul, 0, 0);
      cyc("rw_wait", 0, add1, mul, 0, 1);
      cyc("rw_done", 0, add1, add2, 0, 0);

      if (q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL queue_drain observed=%0d expected=0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time bound exceeded");
   end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Stage-sequencing controller for the 5-stage pipeline (fetch, F/D latch, decode, D/X latch, execute, X/M latch, memory).
- Drives write-enables and flushes on the PC and the three pipeline latches.
- Resolves three hazards: load-use, taken-branch/jump redirect, and multi-cycle mult/div occupancy of execute.
- Also keeps saturating stall/flush counters for debug readout.

Parameters:
- MD_MAX_CYCLES, 40: cycles in MD_WAIT before the watchdog forces release.
- CNT_WIDTH, 16: width of the performance counters.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- fd_ir  in  32  instruction held in the F/D latch.
- de_ir  in  32  instruction held in the D/X latch.
- branch_taken  in  1  execute stage resolved a taken bne/blt, or de_ir is j/jal/jr.
- multdiv_ready  in  1  mult/div unit result valid.
- pc_wren  out  1  PC register write-enable.
- fd_wren  out  1  F/D latch write-enable.
- fd_flush  out  1  F/D latch loads nop (32'b0).
- de_wren  out  1  D/X latch write-enable.
- de_flush  out  1  D/X latch loads nop.
- em_bubble  out  1  X/M latch loads nop instead of the execute result.
- pc_sel_branch  out  1  PC mux selects the branch/jump target.
- multdiv_start  out  1  one-cycle start pulse to the mult/div unit.
- md_busy  out  1  state is MD_WAIT.
- md_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_WIDTH  count of cycles with pc_wren=0.
- flush_events  out  CNT_WIDTH  count of cycles with pc_sel_branch=1.

Behaviour:
Instruction fields:
- opcode=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2].
- R=00000, addi=00101, sw=00111, lw=01000, j=00001, bne=00010, jal=00011, jr=00100, blt=00110.
- mul = R with aluop 00110; div = R with aluop 00111.

Source registers of fd_ir:
- rs: R, addi, lw, sw, bne, blt.
- rt: R only.
- rd: sw, bne, blt, jr.
- Register 0 never causes a hazard.

Load-use hazard (lu):
- Asserted when de_ir opcode=lw, de_ir rd != 0, and de_ir rd equals any source register of fd_ir.

FSM states: RUN, MD_WAIT.
- RUN -> MD_WAIT when de_ir is mul/div and branch_taken=0. multdiv_start=1 for exactly that cycle.
- MD_WAIT -> RUN when multdiv_ready=1, or when the wait counter reaches MD_MAX_CYCLES-1. The watchdog exit sets md_timeout=1, which holds until reset.
- The wait counter clears on entry to MD_WAIT.

Outputs (combinational from state and inputs), highest priority first:
1. reset=1: pc_wren=fd_wren=de_wren=1, fd_flush=de_flush=em_bubble=1, all other outputs 0.
2. Mult/div stall (RUN with mul/div start, or MD_WAIT with no exit this cycle):
   - pc_wren=fd_wren=de_wren=0, em_bubble=1, flushes 0.
3. MD_WAIT exit cycle:
   - All wren=1, em_bubble=0; the mul/div instruction advances to X/M with the result.
4. branch_taken=1 in RUN:
   - pc_sel_branch=1, fd_flush=de_flush=1, all wren=1.
   - branch_taken overrides lu, because the dependent instruction is wrong-path.
5. lu=1:
   - pc_wren=fd_wren=0, de_wren=1, de_flush=1. This is a 1-cycle bubble.
6. Otherwise: all wren=1, flushes/bubble 0.

State and counters:
- Reset values: state=RUN, wait counter=0, md_timeout=0, stall_cycles=0, flush_events=0.
- Counters increment on the cycle the condition holds and saturate at all-ones. They do not count during reset.
- Reset asserted mid-MD_WAIT: the next state is RUN, multdiv_start is not reissued, and no timeout is flagged.
- Latency: stall/flush decisions take effect at the same clock edge as the condition (0-cycle combinational). The FSM state changes one edge later.

Test Plan:
- Load-use: de_ir=lw rd=3, fd_ir=add rs=3 → pc_wren=0, fd_wren=0, de_flush=1 for 1 cycle; stall_cycles 0→1.
- lw into register 0: de_ir=lw rd=0, fd_ir reads r0 → no stall, all wren=1.
- Branch wins over load-use: branch_taken=1 with lu=1 → pc_sel_branch=1, fd_flush=de_flush=1, pc_wren=1; flush_events 0→1, stall_cycles unchanged.
- Mult/div sequence: de_ir=mul, multdiv_ready rises 5 cycles after start → multdiv_start pulses once; md_busy=1 for 5 cycles; em_bubble=1 for 5 cycles then 0; stall_cycles +5.
- Watchdog: MD_MAX_CYCLES=8, multdiv_ready held 0 → exit after 8 MD_WAIT cycles; md_timeout=1 and stays 1 until reset.
- Reset mid-wait: reset at the 3rd MD_WAIT cycle → next cycle state=RUN, counters 0, md_timeout=0; multdiv_start stays 0 during reset.
